// File: rtl/rot_pkg.sv
// rot_pkg: shared types and helpers for the rotation angle controller.
//   state_e    : controller FSM states
//   ANGLE_W    : LUT address width
//   COEF_W     : signed sin/cos coefficient width
//   COS_RESET  : cos coefficient held out of reset (1.0 ~ 127)
//   angle_red  : single-subtract reduction of an angle into 0..steps-1
package rot_pkg;
  localparam int ANGLE_W = 7;
  localparam int COEF_W  = 8;
  localparam logic signed [COEF_W-1:0] COS_RESET = 8'sd127;

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, LOOKUP} state_e;

  // Inputs never exceed 2*steps-1, so one conditional subtract suffices.
  function automatic logic [ANGLE_W-1:0] angle_red(input logic [ANGLE_W:0] v,
                                                   input int steps);
    logic [ANGLE_W:0] r;
    r = (int'(v) >= steps) ? v - (ANGLE_W+1)'(steps) : v;
    return r[ANGLE_W-1:0];
  endfunction
endpackage

// File: rtl/rotation_angle_ctrl_if.sv
// rotation_angle_ctrl_if: switch inputs, LUT pair and mapper coefficients.
//   iFRAME_SYNC : frame-end pulse from the pixel mapper
//   iAUTO/iSTEP : mode select and step / absolute angle
//   iDIR        : auto-rotate direction (only with ROT_DIR_EN)
//   oTHETA      : LUT address; iSIN/iCOS LUT data back
//   oSIN/oCOS   : committed coefficients, oUPDATE pulse, oBUSY
// slave = controller side, master = environment side.
interface rotation_angle_ctrl_if;
  import rot_pkg::*;
  logic                      iFRAME_SYNC;
  logic                      iAUTO;
  logic [ANGLE_W-1:0]        iSTEP;
`ifdef ROT_DIR_EN
  logic                      iDIR;
`endif
  logic [ANGLE_W-1:0]        oTHETA;
  logic signed [COEF_W-1:0]  iSIN, iCOS;
  logic signed [COEF_W-1:0]  oSIN, oCOS;
  logic                      oUPDATE;
  logic                      oBUSY;

  modport slave (
    input  iFRAME_SYNC, iAUTO, iSTEP, iSIN, iCOS,
`ifdef ROT_DIR_EN
    input  iDIR,
`endif
    output oTHETA, oSIN, oCOS, oUPDATE, oBUSY
  );

  modport master (
    output iFRAME_SYNC, iAUTO, iSTEP, iSIN, iCOS,
`ifdef ROT_DIR_EN
    output iDIR,
`endif
    input  oTHETA, oSIN, oCOS, oUPDATE, oBUSY
  );
endinterface

// File: rtl/rot_tick_gen.sv
// rot_tick_gen: free-running 0..TICK_DIV-1 counter; tick_o is a registered
// one-cycle pulse following each wrap.
//   CLK, RESET_N : clock, async active-low reset
//   tick_o       : auto-rotate tick
module rot_tick_gen #(
  parameter int TICK_DIV = 5000000
) (
  input  logic CLK,
  input  logic RESET_N,
  output logic tick_o
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == LAST);
    cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;
endmodule

// File: rtl/rotation_angle_ctrl.sv
// rotation_angle_ctrl: owns the sin/cos LUT address and commits new
// coefficients to the pixel mapper only at a frame boundary.
//   CLK, RESET_N : clock, async active-low reset
//   bus          : rotation_angle_ctrl_if.slave (switches, LUT, mapper)
// Optional feature macro: ROT_DIR_EN adds iDIR (1 = rotate backwards).
module rotation_angle_ctrl
  import rot_pkg::*;
#(
  parameter int TICK_DIV    = 5000000,
  parameter int ANGLE_STEPS = 72,
  parameter int LUT_LATENCY = 1
) (
  input  logic CLK,
  input  logic RESET_N,
  rotation_angle_ctrl_if.slave bus
);
  localparam int WW = (LUT_LATENCY > 0) ? $clog2(LUT_LATENCY + 1) : 1;
  localparam logic [WW-1:0] WLAST = WW'(LUT_LATENCY);

  logic tick;

  rot_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .tick_o (tick)
  );

  state_e                   state_q, state_d;
  logic                     pending_q, pending_d;
  logic [WW-1:0]            wait_q, wait_d;
  logic [ANGLE_W-1:0]       theta_q, theta_d;
  logic signed [COEF_W-1:0] sin_q, sin_d, cos_q, cos_d;
  logic                     update_q, update_d;

  logic [ANGLE_W-1:0] step_red, fwd_angle, next_angle;
  logic               enter_lookup;
`ifdef ROT_DIR_EN
  logic [ANGLE_W-1:0] back_angle;
`endif

  always_comb begin
    step_red  = angle_red({1'b0, bus.iSTEP}, ANGLE_STEPS);
    fwd_angle = angle_red({1'b0, theta_q} + {1'b0, step_red}, ANGLE_STEPS);
`ifdef ROT_DIR_EN
    // Add a full turn before subtracting so the sum never goes negative.
    back_angle = angle_red({1'b0, theta_q} + 8'(ANGLE_STEPS) - {1'b0, step_red},
                           ANGLE_STEPS);
    next_angle = !bus.iAUTO ? step_red : (bus.iDIR ? back_angle : fwd_angle);
`else
    next_angle = bus.iAUTO ? fwd_angle : step_red;
`endif
  end

  // Mode is sampled at the commit edge, so a mid-wait mode change applies.
  assign enter_lookup = (state_q == WAIT_FRAME) && bus.iFRAME_SYNC;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    theta_d  = theta_q;
    sin_d    = sin_q;
    cos_d    = cos_q;
    update_d = 1'b0;
    // Single flag: extra ticks are absorbed. A tick coinciding with the
    // commit edge is kept for the next pass; the manual compare is not,
    // since it still sees the old angle on that edge.
    if (enter_lookup)
      pending_d = bus.iAUTO & tick;
    else
      pending_d = pending_q | (bus.iAUTO ? tick : (step_red != theta_q));

    unique case (state_q)
      IDLE: begin
        if (pending_q) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (bus.iFRAME_SYNC) begin
          theta_d = next_angle;
          wait_d  = '0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (wait_q == WLAST) begin
          sin_d    = bus.iSIN;
          cos_d    = bus.iCOS;
          update_d = 1'b1;
          state_d  = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      wait_q    <= '0;
      theta_q   <= '0;
      sin_q     <= '0;
      cos_q     <= COS_RESET;
      update_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      wait_q    <= wait_d;
      theta_q   <= theta_d;
      sin_q     <= sin_d;
      cos_q     <= cos_d;
      update_q  <= update_d;
    end
  end

  assign bus.oTHETA  = theta_q;
  assign bus.oSIN    = sin_q;
  assign bus.oCOS    = cos_q;
  assign bus.oUPDATE = update_q;
  assign bus.oBUSY   = (state_q != IDLE);
endmodule

// File: tb/tb_rotation_angle_ctrl.sv
module tb_rotation_angle_ctrl;
  import rot_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rotation_angle_ctrl_if bus();

  rotation_angle_ctrl #(.TICK_DIV(8), .ANGLE_STEPS(72), .LUT_LATENCY(1)) dut (
    .CLK    (clk),
    .RESET_N(rst_n),
    .bus    (bus)
  );

  // LUT model: sin = addr, cos = 100 - addr, one-cycle registered read.
  always @(posedge clk) begin
    bus.iSIN <= 8'(bus.oTHETA);
    bus.iCOS <= 8'(100 - int'(bus.oTHETA));
  end

  int vectors = 0;
  int errors  = 0;
  int n_upd   = 0;

  typedef struct {int sin_v; int cos_v;} exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every update must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.oUPDATE === 1'b1) begin
      n_upd++;
      if (sb.size() == 0) chk("spurious_update", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_sin", int'(bus.oSIN), e.sin_v);
        chk("sb_cos", int'(bus.oCOS), e.cos_v);
      end
    end
  end

  task automatic wait_busy(input string name);
    int n = 0;
    while (bus.oBUSY !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.oBUSY !== 1'b1) chk({name, "_busy_timeout"}, 0, 1);
  endtask

  // Drive one frame sync at a negedge and check commit timing.
  task automatic sync_pass(input string name, input int exp_theta);
    exp_t e;
    wait_busy(name);
    e.sin_v = exp_theta;
    e.cos_v = 100 - exp_theta;
    sb.push_back(e);
    bus.iFRAME_SYNC = 1'b1;
    @(posedge clk); #1;
    bus.iFRAME_SYNC = 1'b0;
    chk({name, "_theta"}, int'(bus.oTHETA), exp_theta);
    @(negedge clk); chk({name, "_upd_c0"}, int'(bus.oUPDATE), 0);
    @(negedge clk); chk({name, "_upd_c1"}, int'(bus.oUPDATE), 0);
    @(negedge clk); chk({name, "_upd_c2"}, int'(bus.oUPDATE), 1);
    @(negedge clk); chk({name, "_upd_c3"}, int'(bus.oUPDATE), 0);
  endtask

  typedef struct {int step; int exp_theta;} vec_t;
  vec_t mv[6];

  initial begin
    int u0;
    bit busy_ok;
    mv[0] = '{10, 10};
    mv[1] = '{100, 28};
    mv[2] = '{71, 71};
    mv[3] = '{72, 0};
    mv[4] = '{127, 55};
    mv[5] = '{70, 70};

    bus.iFRAME_SYNC = 1'b0;
    bus.iAUTO = 1'b0;
    bus.iSTEP = '0;
`ifdef ROT_DIR_EN
    bus.iDIR = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_theta",  int'(bus.oTHETA), 0);
    chk("rst_sin",    int'(bus.oSIN), 0);
    chk("rst_cos",    int'(bus.oCOS), 127);
    chk("rst_update", int'(bus.oUPDATE), 0);
    chk("rst_busy",   int'(bus.oBUSY), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", int'(bus.oBUSY), 0);

    // Manual mode table.
    for (int i = 0; i < 6; i++) begin
      bus.iSTEP = 7'(mv[i].step);
      @(negedge clk);
      sync_pass($sformatf("man%0d", i), mv[i].exp_theta);
    end

    // Auto: theta 70 + 5 wraps to 3.
    bus.iAUTO = 1'b1;
    bus.iSTEP = 7'd5;
    sync_pass("auto_wrap", 3);

    // Auto: several ticks with no sync collapse into one +5 update.
    wait_busy("auto_hold");
    u0 = n_upd;
    busy_ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.oBUSY !== 1'b1) busy_ok = 1'b0;
    end
    chk("auto_hold_busy", int'(busy_ok), 1);
    chk("auto_hold_no_upd", n_upd - u0, 0);
    sync_pass("auto_hold", 8);
    chk("auto_hold_one_upd", n_upd - u0, 1);

    // Reset in the middle of LOOKUP: nothing is committed.
    bus.iAUTO = 1'b0;
    bus.iSTEP = 7'd20;
    @(negedge clk);
    wait_busy("rst_mid");
    bus.iFRAME_SYNC = 1'b1;
    @(posedge clk); #1;
    bus.iFRAME_SYNC = 1'b0;
    chk("rst_mid_theta_pre", int'(bus.oTHETA), 20);
    rst_n = 1'b0;
    bus.iSTEP = '0;
    u0 = n_upd;
    @(negedge clk);
    chk("rst_mid_theta",  int'(bus.oTHETA), 0);
    chk("rst_mid_sin",    int'(bus.oSIN), 0);
    chk("rst_mid_cos",    int'(bus.oCOS), 127);
    chk("rst_mid_update", int'(bus.oUPDATE), 0);
    chk("rst_mid_busy",   int'(bus.oBUSY), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_mid_no_upd", n_upd - u0, 0);
    chk("rst_mid_idle", int'(bus.oBUSY), 0);

`ifdef ROT_DIR_EN
    bus.iSTEP = 7'd2;
    @(negedge clk);
    sync_pass("dir_pre", 2);
    bus.iAUTO = 1'b1;
    bus.iDIR = 1'b1;
    bus.iSTEP = 7'd5;
    sync_pass("dir_back", 69);
`endif

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
